idma_eh_responder: RTL and testbench
====================================

# idma_eh_responder

Error-handling responder that sits directly downstream of the iDMA error handler. It consumes every 1D response the error handler emits, counts completed transfers, and captures the first bus error into sticky status registers. For each error response it produces the matching error-handling decision (CONTINUE or ABORT), taken either automatically from a configured policy or from a software command.

## Interface
Parameters:
- `AddrWidth`, 32, width of burst address in error reports
- `CntWidth`, 32, width of completed-transfer counter
- `ErrCntWidth`, 8, width of saturating error counter

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; **one clock; reset is synchronous and active-high**
- `rsp_valid_i`  in  1  1D response valid from error handler
- `rsp_ready_o`  out  1  1D response ready
- `rsp_error_i`  in  1  response reports an error
- `rsp_last_i`  in  1  response belongs to last 1D transfer of an ND job
- `rsp_cause_i`  in  2  AXI resp code of the error
- `rsp_err_type_i`  in  2  error type (BUS_READ / BUS_WRITE encoding from idma_pkg)
- `rsp_burst_addr_i`  in  AddrWidth  faulting burst address
- `eh_o`  out  1  decision: 0 = CONTINUE, 1 = ABORT
- `eh_valid_o`  out  1  decision valid
- `eh_ready_i`  in  1  decision accepted by error handler
- `cfg_mode_i`  in  2  policy: 0 auto-CONTINUE, 1 auto-ABORT, 2/3 software
- `sw_eh_i`  in  1  software decision
- `sw_eh_valid_i`  in  1  software decision valid
- `sw_eh_ready_o`  out  1  software decision ready
- `err_clear_i`  in  1  clear sticky error status and error count
- `err_valid_o`  out  1  sticky: an error has been captured
- `err_cause_o`  out  2  captured cause
- `err_type_o`  out  2  captured type
- `err_addr_o`  out  AddrWidth  captured burst address
- `err_count_o`  out  ErrCntWidth  number of errors since clear, saturating
- `xfer_count_o`  out  CntWidth  non-error responses accepted, wrapping
- `done_irq_o`  out  1  one-cycle pulse: non-error response with last
- `err_irq_o`  out  1  one-cycle pulse: error response accepted
- `busy_o`  out  1  FSM not in IDLE

## Operation
- FSM states:
  - IDLE: `rsp_ready_o`=1.
  - SW_WAIT: `sw_eh_ready_o`=1, `rsp_ready_o`=0.
  - ISSUE: `eh_valid_o`=1, `rsp_ready_o`=0.
- In IDLE, a response handshake with `rsp_error_i`=0:
  - `xfer_count_o` increments by 1, wrapping from 2^CntWidth-1 to 0.
  - If `rsp_last_i`=1, `done_irq_o` pulses.
  - The state stays IDLE.
- In IDLE, a response handshake with `rsp_error_i`=1:
  - `err_irq_o` pulses.
  - `err_count_o` increments, saturating at all-ones.
  - If `err_valid_o`=0, capture cause, type and address, and set `err_valid_o`. Later errors do not overwrite the captured fields.
  - `cfg_mode_i` is sampled in the same cycle.
  - Mode 0 or 1: latch decision 0 or 1 respectively and go to ISSUE.
  - Mode 2 or 3: go to SW_WAIT.
- In SW_WAIT, a handshake on `sw_eh_valid_i` latches `sw_eh_i` as the decision and moves to ISSUE. `sw_eh_ready_o` is 0 in every other state.
- In ISSUE, `eh_o` holds the latched decision, stable while valid. On `eh_ready_i`, return to IDLE.
- After an ABORT (or CONTINUE on a last write burst), the upstream block emits an extra non-error response. This responder handles it as an ordinary response in IDLE.
- `err_clear_i` in the same cycle as an error capture: the capture wins. The result is `err_valid_o`=1, new fields, `err_count_o`=1.
- `err_clear_i` alone: `err_valid_o`=0, `err_count_o`=0. Captured fields are zeroed. `xfer_count_o` is unaffected.
- Changing `cfg_mode_i` outside an error acceptance cycle has no effect on a pending decision.

## Timing
- Reset (`rst_i`=1 at a rising edge), all cycles:
  - State goes to IDLE; all registers clear to 0.
  - `rsp_ready_o`=1 from the first cycle after reset. Every other output is 0.
- Reset mid-operation (SW_WAIT or ISSUE) drops the pending decision. No `eh_valid_o` follows.
- All outputs are driven from registers or decoded from registered state only. There are no combinational paths from input to output.
- An error response accepted at edge N gives, in cycle N+1:
  - `err_irq_o`=1, status and counters updated.
  - Auto mode: `eh_valid_o`=1.
  - Software mode: `sw_eh_ready_o`=1.
- A software decision accepted at edge M gives `eh_valid_o`=1 in cycle M+1.
- An `eh_ready_i` handshake at edge K gives `rsp_ready_o`=1 in cycle K+1.
- IRQ pulses are exactly one cycle long. Back-to-back non-error last responses give consecutive pulses.
- Throughput in IDLE is one response per cycle.

## Test plan
- After reset, check the reset values of all outputs. Then send 3 non-error responses, last=0,0,1. Required: `xfer_count_o`=3, exactly one `done_irq_o` pulse, in the cycle after the third response.
- Mode 0: send a write error (cause 2'b10, addr 0x1000). Required:
  - next cycle: `eh_valid_o`=1, `eh_o`=0, `err_valid_o`=1, `err_addr_o`=0x1000;
  - `eh_ready_i` held low for 3 cycles: `eh_o` stays stable and `rsp_ready_o` stays 0.
- Mode 1: send two errors (addr 0x2000 then 0x3000), each acknowledged. Required: `eh_o`=1 both times, `err_addr_o`=0x2000, `err_count_o`=2.
- Mode 2: send an error, then `sw_eh_i`=1 after 5 cycles. Required:
  - `eh_valid_o` stays low until the cycle after the software handshake, then `eh_o`=1;
  - after `eh_ready_i`, a following extra non-error response increments `xfer_count_o`.
- Boundaries:
  - `err_clear_i` together with an error: `err_count_o`=1, `err_valid_o`=1.
  - `err_count_o` saturates at 255 after 300 errors.
  - `xfer_count_o` wraps from 0xFFFFFFFF to 0.
- Assert `rst_i` in SW_WAIT. Required: next cycle IDLE, `busy_o`=0, all status registers 0, `eh_valid_o` never asserted.

Source files
------------

// File: rtl/idma_eh_responder.sv
// idma_eh_responder: consumes 1D responses from the iDMA error handler,
// counts completed transfers, captures the first bus error in sticky status
// registers and returns a CONTINUE/ABORT decision for every error response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits for ready, and ready is decoded from state only.
module idma_eh_responder #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned CntWidth    = 32,
    parameter int unsigned ErrCntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rsp_valid_i,
    output logic                   rsp_ready_o,
    input  logic                   rsp_error_i,
    input  logic                   rsp_last_i,
    input  logic [1:0]             rsp_cause_i,
    input  logic [1:0]             rsp_err_type_i,
    input  logic [AddrWidth-1:0]   rsp_burst_addr_i,
    output logic                   eh_o,
    output logic                   eh_valid_o,
    input  logic                   eh_ready_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic                   sw_eh_i,
    input  logic                   sw_eh_valid_i,
    output logic                   sw_eh_ready_o,
    input  logic                   err_clear_i,
    output logic                   err_valid_o,
    output logic [1:0]             err_cause_o,
    output logic [1:0]             err_type_o,
    output logic [AddrWidth-1:0]   err_addr_o,
    output logic [ErrCntWidth-1:0] err_count_o,
    output logic [CntWidth-1:0]    xfer_count_o,
    output logic                   done_irq_o,
    output logic                   err_irq_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SW_WAIT = 2'd1,
        ISSUE   = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   decision_q;
    logic                   err_valid_q, err_valid_d;
    logic [1:0]             err_cause_q, err_cause_d;
    logic [1:0]             err_type_q, err_type_d;
    logic [AddrWidth-1:0]   err_addr_q, err_addr_d;
    logic [ErrCntWidth-1:0] err_count_q, err_count_d;
    logic [CntWidth-1:0]    xfer_count_q, xfer_count_d;
    logic                   done_irq_q, err_irq_q;

    logic rsp_hs, ok_hs, err_hs, capture;

    assign rsp_hs  = (state_q == IDLE) && rsp_valid_i;
    assign ok_hs   = rsp_hs && !rsp_error_i;
    assign err_hs  = rsp_hs && rsp_error_i;
    // A clear in the same cycle as an error lets the new error be captured.
    assign capture = err_hs && (!err_valid_q || err_clear_i);

    // Decision FSM: latch the policy or software decision, then offer it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            decision_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (err_hs) begin
                        if (!cfg_mode_i[1]) begin
                            decision_q <= cfg_mode_i[0];
                            state_q    <= ISSUE;
                        end else begin
                            state_q    <= SW_WAIT;
                        end
                    end
                end
                SW_WAIT: begin
                    if (sw_eh_valid_i) begin
                        decision_q <= sw_eh_i;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eh_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next values of the status and counter registers.
    always_comb begin
        err_valid_d  = err_valid_q;
        err_cause_d  = err_cause_q;
        err_type_d   = err_type_q;
        err_addr_d   = err_addr_q;
        err_count_d  = err_count_q;
        xfer_count_d = xfer_count_q;
        if (ok_hs) begin
            xfer_count_d = xfer_count_q + CntWidth'(1);
        end
        if (err_hs) begin
            if (err_clear_i) begin
                err_count_d = ErrCntWidth'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + ErrCntWidth'(1);
            end
            if (capture) begin
                err_valid_d = 1'b1;
                err_cause_d = rsp_cause_i;
                err_type_d  = rsp_err_type_i;
                err_addr_d  = rsp_burst_addr_i;
            end
        end else if (err_clear_i) begin
            err_valid_d = 1'b0;
            err_cause_d = '0;
            err_type_d  = '0;
            err_addr_d  = '0;
            err_count_d = '0;
        end
    end

    // Status, counter and interrupt registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_q  <= 1'b0;
            err_cause_q  <= '0;
            err_type_q   <= '0;
            err_addr_q   <= '0;
            err_count_q  <= '0;
            xfer_count_q <= '0;
            done_irq_q   <= 1'b0;
            err_irq_q    <= 1'b0;
        end else begin
            err_valid_q  <= err_valid_d;
            err_cause_q  <= err_cause_d;
            err_type_q   <= err_type_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
            xfer_count_q <= xfer_count_d;
            done_irq_q   <= ok_hs && rsp_last_i;
            err_irq_q    <= err_hs;
        end
    end

    assign rsp_ready_o   = (state_q == IDLE);
    assign sw_eh_ready_o = (state_q == SW_WAIT);
    assign eh_valid_o    = (state_q == ISSUE);
    assign busy_o        = (state_q != IDLE);
    assign eh_o          = decision_q;
    assign err_valid_o   = err_valid_q;
    assign err_cause_o   = err_cause_q;
    assign err_type_o    = err_type_q;
    assign err_addr_o    = err_addr_q;
    assign err_count_o   = err_count_q;
    assign xfer_count_o  = xfer_count_q;
    assign done_irq_o    = done_irq_q;
    assign err_irq_o     = err_irq_q;

endmodule

// File: tb/tb_idma_eh_responder.sv
// Bench for idma_eh_responder: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the responder.
module tb_idma_eh_responder;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;   // small so the wrap-around is reachable
  localparam int ERR_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic              rsp_valid_i, rsp_error_i, rsp_last_i;
  logic [1:0]        rsp_cause_i, rsp_err_type_i;
  logic [ADDR_W-1:0] rsp_burst_addr_i;
  logic              eh_ready_i;
  logic [1:0]        cfg_mode_i;
  logic              sw_eh_i, sw_eh_valid_i, err_clear_i;

  logic              rsp_ready_o, eh_o, eh_valid_o, sw_eh_ready_o;
  logic              err_valid_o, done_irq_o, err_irq_o, busy_o;
  logic [1:0]        err_cause_o, err_type_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic [ERR_W-1:0]  err_count_o;
  logic [CNT_W-1:0]  xfer_count_o;

  idma_eh_responder #(
    .AddrWidth(ADDR_W), .CntWidth(CNT_W), .ErrCntWidth(ERR_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_error_i(rsp_error_i), .rsp_last_i(rsp_last_i),
    .rsp_cause_i(rsp_cause_i), .rsp_err_type_i(rsp_err_type_i),
    .rsp_burst_addr_i(rsp_burst_addr_i),
    .eh_o(eh_o), .eh_valid_o(eh_valid_o), .eh_ready_i(eh_ready_i),
    .cfg_mode_i(cfg_mode_i), .sw_eh_i(sw_eh_i),
    .sw_eh_valid_i(sw_eh_valid_i), .sw_eh_ready_o(sw_eh_ready_o),
    .err_clear_i(err_clear_i), .err_valid_o(err_valid_o),
    .err_cause_o(err_cause_o), .err_type_o(err_type_o),
    .err_addr_o(err_addr_o), .err_count_o(err_count_o),
    .xfer_count_o(xfer_count_o), .done_irq_o(done_irq_o),
    .err_irq_o(err_irq_o), .busy_o(busy_o)
  );

  // ---------------- scoreboard / checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks what software would see: whether an error decision is
  // owed to software or to the error handler, the decision itself, and the
  // status/counter values as plain integers.
  bit              m_need_sw;     // error accepted, software has not answered
  bit              m_offering;    // decision waiting for the error handler
  bit              m_dec;
  int              m_xfer;
  int              m_errs;
  bit              m_have_err;
  logic [1:0]      m_cause, m_type;
  logic [ADDR_W-1:0] m_addr;
  bit              m_done, m_eirq;

  function automatic void model_reset();
    m_need_sw = 0; m_offering = 0; m_dec = 0;
    m_xfer = 0; m_errs = 0; m_have_err = 0;
    m_cause = '0; m_type = '0; m_addr = '0;
    m_done = 0; m_eirq = 0;
  endfunction

  function automatic void model_step();
    bit accepting;
    if (rst_i) begin
      model_reset();
      return;
    end
    accepting = !m_need_sw && !m_offering;
    m_done = 0;
    m_eirq = 0;
    if (accepting && rsp_valid_i && !rsp_error_i) begin
      m_xfer = (m_xfer + 1) % (1 << CNT_W);
      m_done = rsp_last_i;
    end
    if (accepting && rsp_valid_i && rsp_error_i) begin
      m_eirq = 1;
      if (err_clear_i) m_errs = 1;
      else if (m_errs < (1 << ERR_W) - 1) m_errs = m_errs + 1;
      if (!m_have_err || err_clear_i) begin
        m_have_err = 1;
        m_cause = rsp_cause_i;
        m_type  = rsp_err_type_i;
        m_addr  = rsp_burst_addr_i;
      end
      if (cfg_mode_i == 2'd0)      begin m_dec = 0; m_offering = 1; end
      else if (cfg_mode_i == 2'd1) begin m_dec = 1; m_offering = 1; end
      else                         m_need_sw = 1;
    end else begin
      if (err_clear_i) begin
        m_have_err = 0; m_errs = 0;
        m_cause = '0; m_type = '0; m_addr = '0;
      end
      if (m_need_sw && sw_eh_valid_i) begin
        m_dec = sw_eh_i; m_need_sw = 0; m_offering = 1;
      end else if (m_offering && eh_ready_i) begin
        m_offering = 0;
      end
    end
  endfunction

  task automatic check_all();
    check_eq("rsp_ready",  rsp_ready_o,   !m_need_sw && !m_offering);
    check_eq("sw_ready",   sw_eh_ready_o, m_need_sw);
    check_eq("eh_valid",   eh_valid_o,    m_offering);
    check_eq("busy",       busy_o,        m_need_sw || m_offering);
    check_eq("eh",         eh_o,          m_dec);
    check_eq("err_valid",  err_valid_o,   m_have_err);
    check_eq("err_cause",  err_cause_o,   m_cause);
    check_eq("err_type",   err_type_o,    m_type);
    check_eq("err_addr",   err_addr_o,    m_addr);
    check_eq("err_count",  err_count_o,   m_errs);
    check_eq("xfer_count", xfer_count_o,  m_xfer);
    check_eq("done_irq",   done_irq_o,    m_done);
    check_eq("err_irq",    err_irq_o,     m_eirq);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst_i = 0; rsp_valid_i = 0; rsp_error_i = 0; rsp_last_i = 0;
    rsp_cause_i = '0; rsp_err_type_i = '0; rsp_burst_addr_i = '0;
    eh_ready_i = 0; sw_eh_i = 0; sw_eh_valid_i = 0; err_clear_i = 0;
  endtask

  // One clock: model consumes the current inputs, DUT samples them, compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_rsp(input bit err, input bit last, input logic [1:0] cause,
                          input logic [1:0] typ, input logic [ADDR_W-1:0] addr);
    rsp_valid_i = 1; rsp_error_i = err; rsp_last_i = last;
    rsp_cause_i = cause; rsp_err_type_i = typ; rsp_burst_addr_i = addr;
    cycle();
    idle_inputs();
  endtask

  task automatic ack_eh();
    eh_ready_i = 1;
    cycle();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    cycle();
    rst_i = 0;
  endtask

  // ---------------- stimulus ----------------
  int x0;

  initial begin
    idle_inputs();
    cfg_mode_i = 2'd0;
    rst_i = 1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check_eq("reset_rsp_ready", rsp_ready_o, 1'b1);
    check_eq("reset_xfer", xfer_count_o, 0);

    // Three plain responses, only the last one flagged last.
    send_rsp(0, 0, 2'b00, 2'b00, 32'h0);
    check_eq("done_after_1", done_irq_o, 1'b0);
    send_rsp(0, 0, 2'b00, 2'b00, 32'h0);
    check_eq("done_after_2", done_irq_o, 1'b0);
    send_rsp(0, 1, 2'b00, 2'b00, 32'h0);
    check_eq("done_after_3", done_irq_o, 1'b1);
    check_eq("xfer_is_3", xfer_count_o, 3);
    cycle();
    check_eq("done_one_cycle", done_irq_o, 1'b0);

    // Mode 0: auto-CONTINUE, held off by the error handler for 3 cycles.
    cfg_mode_i = 2'd0;
    send_rsp(1, 0, 2'b10, 2'b01, 32'h1000);
    check_eq("m0_eh_valid", eh_valid_o, 1'b1);
    check_eq("m0_eh", eh_o, 1'b0);
    check_eq("m0_err_valid", err_valid_o, 1'b1);
    check_eq("m0_err_addr", err_addr_o, 32'h1000);
    check_eq("m0_err_irq", err_irq_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("m0_hold_eh", eh_o, 1'b0);
      check_eq("m0_hold_rsp_ready", rsp_ready_o, 1'b0);
    end
    ack_eh();
    check_eq("m0_back_idle", rsp_ready_o, 1'b1);

    // Mode 1: two aborts, first address stays captured.
    err_clear_i = 1;
    cycle();
    idle_inputs();
    cfg_mode_i = 2'd1;
    send_rsp(1, 0, 2'b11, 2'b00, 32'h2000);
    check_eq("m1_eh_first", eh_o, 1'b1);
    ack_eh();
    send_rsp(1, 0, 2'b10, 2'b01, 32'h3000);
    check_eq("m1_eh_second", eh_o, 1'b1);
    ack_eh();
    check_eq("m1_addr_first", err_addr_o, 32'h2000);
    check_eq("m1_count_2", err_count_o, 2);

    // Mode 2: software answers ABORT after 5 cycles.
    cfg_mode_i = 2'd2;
    send_rsp(1, 0, 2'b10, 2'b01, 32'h5000);
    check_eq("m2_sw_ready", sw_eh_ready_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("m2_no_eh_valid", eh_valid_o, 1'b0);
    end
    sw_eh_valid_i = 1; sw_eh_i = 1;
    cycle();
    idle_inputs();
    check_eq("m2_eh_valid", eh_valid_o, 1'b1);
    check_eq("m2_eh", eh_o, 1'b1);
    ack_eh();
    x0 = m_xfer;
    send_rsp(0, 1, 2'b00, 2'b00, 32'h0);
    check_eq("m2_extra_rsp", xfer_count_o, (x0 + 1) % (1 << CNT_W));

    // Clear together with a new error: capture wins.
    cfg_mode_i = 2'd0;
    err_clear_i = 1;
    send_rsp(1, 0, 2'b01, 2'b00, 32'h4000);
    check_eq("clr_cap_count", err_count_o, 1);
    check_eq("clr_cap_valid", err_valid_o, 1'b1);
    check_eq("clr_cap_addr", err_addr_o, 32'h4000);
    ack_eh();

    // Saturation of the error counter.
    err_clear_i = 1;
    cycle();
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      send_rsp(1, 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), $urandom);
      ack_eh();
    end
    check_eq("err_sat", err_count_o, 255);

    // Wrap of the transfer counter, back-to-back responses.
    do_reset();
    rsp_valid_i = 1;
    for (int i = 0; i < 255; i++) cycle();
    idle_inputs();
    check_eq("xfer_max", xfer_count_o, 255);
    send_rsp(0, 0, 2'b00, 2'b00, 32'h0);
    check_eq("xfer_wrap", xfer_count_o, 0);

    // Reset while waiting for software drops the decision.
    cfg_mode_i = 2'd3;
    send_rsp(1, 0, 2'b10, 2'b00, 32'h6000);
    check_eq("rst_sw_ready", sw_eh_ready_o, 1'b1);
    do_reset();
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_err_valid", err_valid_o, 1'b0);
    check_eq("rst_err_count", err_count_o, 0);
    sw_eh_valid_i = 1; sw_eh_i = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("rst_no_eh_valid", eh_valid_o, 1'b0);
    end
    idle_inputs();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_i            = ($urandom_range(0, 299) == 0);
      rsp_valid_i      = $urandom_range(0, 1);
      rsp_error_i      = ($urandom_range(0, 3) == 0);
      rsp_last_i       = $urandom_range(0, 1);
      rsp_cause_i      = 2'($urandom_range(0, 3));
      rsp_err_type_i   = 2'($urandom_range(0, 1));
      rsp_burst_addr_i = $urandom;
      cfg_mode_i       = 2'($urandom_range(0, 3));
      eh_ready_i       = $urandom_range(0, 1);
      sw_eh_valid_i    = ($urandom_range(0, 2) == 0);
      sw_eh_i          = $urandom_range(0, 1);
      err_clear_i      = ($urandom_range(0, 19) == 0);
      cycle();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
